calc_dev_multi: RTL and testbench
=================================

# calc_dev_multi

Multi-accumulator calculator device. It is the parametrised successor to the single-result calculator FSM on the same byte-serial `cs`/`din` command bus. It holds `NACC` independent accumulators and executes a wider opcode set, with optional unsigned saturation. Operand bytes are accepted only when `cs` is high, so the host may insert wait cycles. Illegal commands are reported on a dedicated error pulse.

## Interface
- `DW`, 8: data/accumulator width; must be ≥ 8.
- `NACC`, 4: number of accumulators; 2 or 4. `SW = $clog2(NACC)`.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `cs` in 1: byte strobe; `din` is valid when high.
- `din` in `DW`: command or operand byte.
- `busy` out 1: block is mid-transaction.
- `drdy` out 1: `dout` is valid this cycle.
- `dout` out `DW`: result; 0 whenever `drdy` is low.
- `err` out 1: one-cycle pulse on an illegal opcode.

## Operation
- **Command fields** (bits `DW-1:8` are ignored):
  - `op = din[7:4]`
  - `tx = din[3]`: transmit the selected accumulator after execution.
  - `sat = din[2]`: saturating arithmetic.
  - `sel = din[SW-1:0]`: accumulator select.
- **Opcodes and operand counts** (A = first operand, B = second):
  - 0x0 NOP (0 operands)
  - 0x1 LOAD: acc = A (1 operand)
  - 0x2 ADD2: acc = A+B (2)
  - 0x3 SUB2: acc = A−B (2)
  - 0x4 ACCADD: acc = acc+A (1)
  - 0x5 ACCSUB: acc = acc−A (1)
  - 0x6 AND: acc = A&B (2)
  - 0x7 OR (2)
  - 0x8 XOR (2)
  - 0x9 CLR: acc = 0 (0)
  - 0xA–0xF are illegal.
- **Arithmetic width:** computed at DW+1 bits.
  - `sat=0`: result wraps modulo 2^DW.
  - `sat=1`: unsigned overflow clamps to all-ones; underflow clamps to 0. `sat` has no effect on NOP, LOAD, CLR or the logic ops.
- **States:** IDLE, OPA, OPB, EXEC, TX.
- **Transitions:**
  - IDLE with `cs=1`: latch the command.
    - Illegal opcode: stay in IDLE, `err`=1 next cycle, no state change anywhere.
    - Operand count 0: go to EXEC.
    - Otherwise: go to OPA.
  - OPA with `cs=1`: latch A. Go to OPB if the opcode takes 2 operands, else EXEC. With `cs=0`, hold OPA.
  - OPB with `cs=1`: latch B, go to EXEC. With `cs=0`, hold OPB.
  - EXEC: write `acc[sel]`; go to TX if `tx`, else IDLE. `cs` is ignored.
  - TX: `dout = acc[sel]`, `drdy=1`; go to IDLE. `cs` is ignored.
  - Unused encodings go to IDLE.
- **Independence:** only `acc[sel]` is written. The other accumulators are untouched.

## Timing
- **Reset values:** `busy`=0, `drdy`=0, `err`=0, `dout`=0; all accumulators, the command register and the operand registers are 0; state is IDLE.
- **Registered outputs:**
  - `busy <= (next_state != IDLE)`
  - `drdy <= (next_state == TX)`
  - `err <= illegal-opcode detect`
  - `dout` is driven from state: `acc[sel]` in TX, else 0.
- **Latency for a 2-operand op with `tx=1` and no wait cycles:**
  - Command at edge 0, A at edge 1, B at edge 2.
  - EXEC during cycle 3; `drdy` high during cycle 4.
  - Each cycle with `cs` low in OPA or OPB adds one cycle.
- **Back-to-back:** a new command is accepted in the first IDLE cycle after EXEC or TX. `busy` is low in that cycle.
- **`cs` outside IDLE/OPA/OPB:** `cs=1` in EXEC or TX is dropped. The host must not present bytes then.
- **Reset mid-operation:** asynchronous return to IDLE. All accumulators are cleared and any pending `drdy` is cancelled.
- **Select out of range:** if `NACC` is not a power of two, out-of-range `sel` values are treated as illegal (`err`).

## Test plan
- **ADD2 with transmit:** cmd 0x29 (ADD2, tx, sel=1), A=0x30, B=0x15, `cs` held high → `drdy` high for one cycle, 4 cycles after the command edge, with `dout`=0x45. Then `busy` drops.
- **Saturating add:** cmd 0x10 with A=0xF0, then cmd 0x4C (ACCADD, tx, sat, sel=0) with A=0x20 → `dout`=0xFF. Repeat with cmd 0x48 (no sat) → `dout`=0x10.
- **Operand wait states:** cmd 0x38 (SUB2, tx, sel=0); `cs` low for 3 cycles before each of A=0x05 and B=0x07 → `busy` stays high throughout, then `dout`=0xFE with no saturation. With cmd 0x3C (sat) → `dout`=0x00.
- **Illegal opcode:** cmd 0xF0 → `err` high for exactly 1 cycle, `busy` stays 0, and a NOP tx read (0x08) of `acc[0]` returns its prior value.
- **Accumulator independence:** LOAD 0x11/0x22/0x33/0x44 into sel 0–3, then CLR sel 2, then NOP tx on each → reads 0x11, 0x22, 0x00, 0x44.
- **Reset mid-operation:** assert `rst` low while in OPB → `busy`, `drdy` and `dout` go to 0 immediately, and a NOP tx read afterwards returns 0x00.

Source files
------------

// File: rtl/calc_dev_multi.sv
// Multi-accumulator byte-serial calculator.
// Commands and operands arrive on din while cs is high. NACC accumulators are
// updated by a small opcode set, with optional unsigned saturation. Illegal
// commands produce a one-cycle err pulse and leave all state untouched.
module calc_dev_multi #(
    parameter int unsigned DW   = 8,
    parameter int unsigned NACC = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cs,
    input  logic [DW-1:0] din,
    output logic          busy,
    output logic          drdy,
    output logic [DW-1:0] dout,
    output logic          err
);

    localparam int unsigned SW = (NACC > 1) ? $clog2(NACC) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_OPA,
        S_OPB,
        S_EXEC,
        S_TX
    } state_t;

    typedef enum logic [3:0] {
        OP_NOP    = 4'h0,
        OP_LOAD   = 4'h1,
        OP_ADD2   = 4'h2,
        OP_SUB2   = 4'h3,
        OP_ACCADD = 4'h4,
        OP_ACCSUB = 4'h5,
        OP_AND    = 4'h6,
        OP_OR     = 4'h7,
        OP_XOR    = 4'h8,
        OP_CLR    = 4'h9
    } op_t;

    state_t        state_q, state_d;
    logic [3:0]    op_q;
    logic          tx_q;
    logic          sat_q;
    logic [SW-1:0] sel_q;
    logic [DW-1:0] a_q, b_q;
    logic [DW-1:0] acc_q [NACC];
    logic          busy_q, drdy_q, err_q, err_d;

    logic [3:0]    din_op;
    logic [SW-1:0] din_sel;
    logic          din_illegal;
    logic          cmd_ld, a_ld, b_ld, acc_we;
    logic [DW-1:0] acc_cur, lhs, rhs, result;
    logic [DW:0]   sum, diff;

    function automatic logic [1:0] num_ops(input logic [3:0] op);
        case (op)
            OP_NOP, OP_CLR:                return 2'd0;
            OP_LOAD, OP_ACCADD, OP_ACCSUB: return 2'd1;
            default:                       return 2'd2;
        endcase
    endfunction

    assign din_op      = din[7:4];
    assign din_sel     = din[SW-1:0];
    assign din_illegal = (din_op > OP_CLR) || (32'(din_sel) >= NACC);
    assign acc_cur     = acc_q[sel_q];

    // Execute-stage datapath: arithmetic at DW+1 bits, carry/borrow drives clamping
    always_comb begin
        lhs = acc_cur;
        rhs = a_q;
        if (op_q == OP_ADD2 || op_q == OP_SUB2) begin
            lhs = a_q;
            rhs = b_q;
        end
        sum    = {1'b0, lhs} + {1'b0, rhs};
        diff   = {1'b0, lhs} - {1'b0, rhs};
        result = acc_cur;
        case (op_q)
            OP_LOAD:              result = a_q;
            OP_ADD2, OP_ACCADD:   result = (sat_q && sum[DW])  ? '1 : sum[DW-1:0];
            OP_SUB2, OP_ACCSUB:   result = (sat_q && diff[DW]) ? '0 : diff[DW-1:0];
            OP_AND:               result = a_q & b_q;
            OP_OR:                result = a_q | b_q;
            OP_XOR:               result = a_q ^ b_q;
            OP_CLR:               result = '0;
            default:              result = acc_cur;
        endcase
    end

    // Next-state and load-enable decode for the command sequencer
    always_comb begin
        state_d = state_q;
        cmd_ld  = 1'b0;
        a_ld    = 1'b0;
        b_ld    = 1'b0;
        acc_we  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cs) begin
                    if (din_illegal) begin
                        err_d = 1'b1;
                    end else begin
                        cmd_ld  = 1'b1;
                        state_d = (num_ops(din_op) == 2'd0) ? S_EXEC : S_OPA;
                    end
                end
            end
            S_OPA: begin
                if (cs) begin
                    a_ld    = 1'b1;
                    state_d = (num_ops(op_q) == 2'd2) ? S_OPB : S_EXEC;
                end
            end
            S_OPB: begin
                if (cs) begin
                    b_ld    = 1'b1;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                acc_we  = 1'b1;
                state_d = tx_q ? S_TX : S_IDLE;
            end
            S_TX:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and registered status outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            drdy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != S_IDLE);
            drdy_q  <= (state_d == S_TX);
            err_q   <= err_d;
        end
    end

    // Command, operand and accumulator registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q  <= '0;
            tx_q  <= 1'b0;
            sat_q <= 1'b0;
            sel_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            for (int unsigned i = 0; i < NACC; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            if (cmd_ld) begin
                op_q  <= din_op;
                tx_q  <= din[3];
                sat_q <= din[2];
                sel_q <= din_sel;
            end
            if (a_ld)   a_q <= din;
            if (b_ld)   b_q <= din;
            if (acc_we) acc_q[sel_q] <= result;
        end
    end

    // Result bus is only non-zero while transmitting
    always_comb begin
        dout = (state_q == S_TX) ? acc_cur : '0;
    end

    assign busy = busy_q;
    assign drdy = drdy_q;
    assign err  = err_q;

endmodule

// File: tb/tb_calc_dev_multi.sv
// Self-checking bench for calc_dev_multi: directed vector table, reset
// corner sequences and randomized commands against a transaction-level model.
module tb_calc_dev_multi;

    localparam int DW   = 8;
    localparam int NACC = 4;

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] a;
        logic [7:0] b;
        int         wa;
        int         wb;
        int         exp;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cs  = 1'b0;
    logic [DW-1:0] din = '0;
    logic          busy, drdy, err;
    logic [DW-1:0] dout;

    int checks = 0;
    int errors = 0;
    int model_acc [NACC];
    int nops_tab [16] = '{0, 1, 2, 2, 1, 1, 2, 2, 2, 0, 0, 0, 0, 0, 0, 0};
    vec_t tab [$];

    calc_dev_multi #(.DW(DW), .NACC(NACC)) dut (
        .clk  (clk),
        .rst  (rst),
        .cs   (cs),
        .din  (din),
        .busy (busy),
        .drdy (drdy),
        .dout (dout),
        .err  (err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accumulator value after one command, computed with plain integer arithmetic
    function automatic int ref_result(input int op, input bit sat, input int acc, input int a, input int b);
        int r;
        case (op)
            0:       r = acc;
            1:       r = a;
            2:       r = a + b;
            3:       r = a - b;
            4:       r = acc + a;
            5:       r = acc - a;
            6:       r = a & b;
            7:       r = a | b;
            8:       r = a ^ b;
            default: r = 0;
        endcase
        if (r > 255) r = sat ? 255 : r - 256;
        if (r < 0)   r = sat ? 0 : r + 256;
        return r;
    endfunction

    // Drive one full transaction and check the cycle-by-cycle handshake
    task automatic txn(input logic [7:0] cmd, input logic [7:0] a, input logic [7:0] b,
                       input int wa, input int wb, input int exp, input string tag);
        int n;
        n = nops_tab[cmd[7:4]];
        cs = 1'b1; din = cmd; tick();
        if (cmd[7:4] > 4'd9) begin
            check({tag, ".err_hi"}, err, 1);
            check({tag, ".err_busy"}, busy, 0);
            cs = 1'b0; din = 8'($urandom); tick();
            check({tag, ".err_lo"}, err, 0);
            check({tag, ".err_busy2"}, busy, 0);
            check({tag, ".err_drdy"}, drdy, 0);
            return;
        end
        check({tag, ".err0"}, err, 0);
        check({tag, ".busy_cmd"}, busy, 1);
        if (n >= 1) begin
            cs = 1'b0;
            for (int i = 0; i < wa; i++) begin
                din = 8'($urandom); tick();
                check({tag, ".busy_waitA"}, busy, 1);
            end
            cs = 1'b1; din = a; tick();
        end
        if (n == 2) begin
            cs = 1'b0;
            for (int i = 0; i < wb; i++) begin
                din = 8'($urandom); tick();
                check({tag, ".busy_waitB"}, busy, 1);
            end
            cs = 1'b1; din = b; tick();
        end
        cs = 1'b0; din = 8'($urandom);
        check({tag, ".exec_busy"}, busy, 1);
        check({tag, ".exec_drdy"}, drdy, 0);
        check({tag, ".exec_dout"}, dout, 0);
        tick();
        if (cmd[3]) begin
            check({tag, ".tx_drdy"}, drdy, 1);
            check({tag, ".tx_dout"}, dout, exp);
            check({tag, ".tx_busy"}, busy, 1);
            tick();
        end
        check({tag, ".end_busy"}, busy, 0);
        check({tag, ".end_drdy"}, drdy, 0);
        check({tag, ".end_dout"}, dout, 0);
    endtask

    // Run a transaction and advance the model
    task automatic run(input logic [7:0] cmd, input logic [7:0] a, input logic [7:0] b,
                       input int wa, input int wb, input int exp, input string tag);
        int op, sel, r;
        op  = int'(cmd[7:4]);
        sel = int'(cmd[1:0]);
        r   = ref_result(op, cmd[2], model_acc[sel], int'(a), int'(b));
        txn(cmd, a, b, wa, wb, exp, tag);
        if (op < 10) model_acc[sel] = r;
    endtask

    task automatic clear_model();
        for (int i = 0; i < NACC; i++) model_acc[i] = 0;
    endtask

    initial begin
        logic [7:0] cmd, a, b;
        int         op, sel, exp;

        clear_model();
        rst = 1'b0; cs = 1'b0; din = '0;
        #23;
        check("reset.busy", busy, 0);
        check("reset.drdy", drdy, 0);
        check("reset.dout", dout, 0);
        check("reset.err",  err,  0);
        @(negedge clk); rst = 1'b1;
        tick();

        // cmd, A, B, waitA, waitB, expected dout (used only when tx is set)
        tab.push_back('{8'h29, 8'h30, 8'h15, 0, 0, 8'h45});
        tab.push_back('{8'h10, 8'hF0, 8'h00, 0, 0, 0});
        tab.push_back('{8'h4C, 8'h20, 8'h00, 2, 0, 8'hFF});
        tab.push_back('{8'h10, 8'hF0, 8'h00, 0, 0, 0});
        tab.push_back('{8'h48, 8'h20, 8'h00, 0, 0, 8'h10});
        tab.push_back('{8'h38, 8'h05, 8'h07, 3, 3, 8'hFE});
        tab.push_back('{8'h3C, 8'h05, 8'h07, 3, 3, 8'h00});
        tab.push_back('{8'h10, 8'h5A, 8'h00, 0, 0, 0});
        tab.push_back('{8'hF0, 8'h00, 8'h00, 0, 0, 0});
        tab.push_back('{8'h08, 8'h00, 8'h00, 0, 0, 8'h5A});
        tab.push_back('{8'hA0, 8'h00, 8'h00, 0, 0, 0});
        tab.push_back('{8'h08, 8'h00, 8'h00, 0, 0, 8'h5A});
        tab.push_back('{8'h98, 8'h00, 8'h00, 0, 0, 8'h00});
        tab.push_back('{8'h10, 8'h11, 8'h00, 0, 0, 0});
        tab.push_back('{8'h11, 8'h22, 8'h00, 0, 0, 0});
        tab.push_back('{8'h12, 8'h33, 8'h00, 0, 0, 0});
        tab.push_back('{8'h13, 8'h44, 8'h00, 0, 0, 0});
        tab.push_back('{8'h92, 8'h00, 8'h00, 0, 0, 0});
        tab.push_back('{8'h08, 8'h00, 8'h00, 0, 0, 8'h11});
        tab.push_back('{8'h09, 8'h00, 8'h00, 0, 0, 8'h22});
        tab.push_back('{8'h0A, 8'h00, 8'h00, 0, 0, 8'h00});
        tab.push_back('{8'h0B, 8'h00, 8'h00, 0, 0, 8'h44});
        tab.push_back('{8'h6D, 8'hF0, 8'h3C, 1, 2, 8'h30});
        tab.push_back('{8'h79, 8'hF0, 8'h0F, 0, 0, 8'hFF});
        tab.push_back('{8'h89, 8'hFF, 8'h0F, 0, 1, 8'hF0});
        tab.push_back('{8'h5D, 8'hF1, 8'h00, 0, 0, 8'h00});
        tab.push_back('{8'h59, 8'h01, 8'h00, 0, 0, 8'hFF});
        tab.push_back('{8'h2E, 8'h80, 8'h80, 0, 0, 8'hFF});
        tab.push_back('{8'h2A, 8'h80, 8'h80, 0, 0, 8'h00});
        tab.push_back('{8'h4F, 8'h0F, 8'h00, 0, 0, 8'h53});
        tab.push_back('{8'h9B, 8'h00, 8'h00, 0, 0, 8'h00});
        tab.push_back('{8'h1F, 8'hAB, 8'h00, 0, 0, 8'hAB});
        tab.push_back('{8'h3D, 8'h07, 8'h07, 0, 0, 8'h00});
        tab.push_back('{8'h2D, 8'hFF, 8'h00, 0, 0, 8'hFF});
        tab.push_back('{8'h29, 8'hFF, 8'h01, 0, 0, 8'h00});
        tab.push_back('{8'h4D, 8'hFF, 8'h00, 0, 0, 8'hFF});
        tab.push_back('{8'hAF, 8'h00, 8'h00, 0, 0, 0});
        tab.push_back('{8'h0B, 8'h00, 8'h00, 0, 0, 8'hAB});

        foreach (tab[i]) begin
            run(tab[i].cmd, tab[i].a, tab[i].b, tab[i].wa, tab[i].wb, tab[i].exp, "vec");
        end

        // Reset while waiting for operand B
        run(8'h11, 8'h77, 8'h00, 0, 0, 0, "rstB.pre");
        cs = 1'b1; din = 8'h29; tick();
        din = 8'h30; tick();
        cs = 1'b0;
        check("rstB.busy_before", busy, 1);
        #2; rst = 1'b0; #1;
        check("rstB.busy", busy, 0);
        check("rstB.drdy", drdy, 0);
        check("rstB.dout", dout, 0);
        @(negedge clk); rst = 1'b1;
        tick();
        clear_model();
        run(8'h09, 8'h00, 8'h00, 0, 0, 8'h00, "rstB.read");

        // Reset while transmitting a non-zero result
        run(8'h10, 8'hAA, 8'h00, 0, 0, 0, "rstT.pre");
        cs = 1'b1; din = 8'h08; tick();
        cs = 1'b0; tick();
        check("rstT.drdy_before", drdy, 1);
        check("rstT.dout_before", dout, 8'hAA);
        #2; rst = 1'b0; #1;
        check("rstT.drdy", drdy, 0);
        check("rstT.dout", dout, 0);
        check("rstT.busy", busy, 0);
        @(negedge clk); rst = 1'b1;
        tick();
        clear_model();
        run(8'h08, 8'h00, 8'h00, 0, 0, 8'h00, "rstT.read");

        // Randomized commands, including illegal opcodes and operand wait states
        for (int k = 0; k < 300; k++) begin
            cmd = 8'($urandom);
            a   = 8'($urandom);
            b   = 8'($urandom);
            op  = int'(cmd[7:4]);
            sel = int'(cmd[1:0]);
            exp = (op < 10) ? ref_result(op, cmd[2], model_acc[sel], int'(a), int'(b)) : 0;
            run(cmd, a, b, $urandom_range(0, 2), $urandom_range(0, 2), exp, "rand");
        end
        for (int s = 0; s < NACC; s++) begin
            run(8'(8'h08 | s), 8'h00, 8'h00, 0, 0, model_acc[s], "final");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
